branch_update_queue: RTL

In-order queue that tracks predicted conditional branches from fetch until the execute stage resolves them. On each resolution it drives the one-cycle training strobe (`isBranch`, `isTaken`, `InstrPC`) into the 2-bit saturating-counter direction table. It also flags a mispredict with the redirect PC so fetch can restart. It sits between fetch/execute and the direction predictor, and is the sole source of that predictor's update inputs.

---
 rtl/branch_update_queue_if.sv | 38 +++
 rtl/branch_update_queue.sv | 99 +++++++++
 2 files changed

// File: rtl/branch_update_queue_if.sv
`default_nettype none
// ============================================================================
// Module   : branch_update_queue_if
// Purpose  : Fetch/execute side signals of the branch update queue.
// Revision : 1.0  initial release
// ============================================================================
interface branch_update_queue_if #(
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH) + 1
);
  logic             alloc_valid;
  logic [31:0]      alloc_pc;
  logic             alloc_pred;
  logic             alloc_ready;
  logic             res_valid;
  logic             res_taken;
  logic [31:0]      res_target;
  logic             isBranch;
  logic             isTaken;
  logic [31:0]      InstrPC;
  logic             mispredict;
  logic [31:0]      redirect_pc;
  logic [CNT_W-1:0] count;
  logic             underflow;

  modport master (
    output alloc_valid, alloc_pc, alloc_pred, res_valid, res_taken, res_target,
    input  alloc_ready, isBranch, isTaken, InstrPC, mispredict, redirect_pc,
           count, underflow
  );

  modport slave (
    input  alloc_valid, alloc_pc, alloc_pred, res_valid, res_taken, res_target,
    output alloc_ready, isBranch, isTaken, InstrPC, mispredict, redirect_pc,
           count, underflow
  );
endinterface
`default_nettype wire

// File: rtl/branch_update_queue.sv
`default_nettype none
// ============================================================================
// Module   : branch_update_queue
// Purpose  : In-order queue of predicted branches; trains the direction table
//            and flags mispredicts as each branch resolves.
// Revision : 1.0  initial release
// ============================================================================
module branch_update_queue #(
  parameter int DEPTH = 8
) (
  input  wire logic             CLK,
  input  wire logic             RESET,
  branch_update_queue_if.slave  bus
);
  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = $clog2(DEPTH) + 1;

  logic [31:0]        r_mem_pc   [DEPTH];
  logic               r_mem_pred [DEPTH];
  logic [c_PTR_W-1:0] r_head;
  logic [c_PTR_W-1:0] r_tail;
  logic [c_CNT_W-1:0] r_count;
  logic               r_is_branch;
  logic               r_is_taken;
  logic [31:0]        r_instr_pc;
  logic               r_mispredict;
  logic [31:0]        r_redirect_pc;
  logic               r_underflow;

  logic               w_alloc_ready;
  logic               w_res_fire;
  logic               w_res_empty;
  logic               w_mispred;
  logic               w_alloc_fire;
  logic [31:0]        w_head_pc;
  logic               w_head_pred;

  // Full blocks allocation even when a pop is in flight: no bypass path.
  assign w_alloc_ready = !RESET && (r_count < c_CNT_W'(DEPTH));
  assign w_res_empty   = bus.res_valid && (r_count == '0);
  assign w_res_fire    = bus.res_valid && (r_count != '0);
  assign w_head_pc     = r_mem_pc[r_head];
  assign w_head_pred   = r_mem_pred[r_head];
  assign w_mispred     = w_res_fire && (bus.res_taken != w_head_pred);
  // A same-cycle allocate during a mispredict is wrong-path and is dropped.
  assign w_alloc_fire  = bus.alloc_valid && w_alloc_ready && !w_mispred;

  always_ff @(posedge CLK) begin
    if (w_alloc_fire) begin
      r_mem_pc[r_tail]   <= bus.alloc_pc;
      r_mem_pred[r_tail] <= bus.alloc_pred;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (w_mispred) begin
      r_head  <= r_tail;
      r_count <= '0;
    end else begin
      if (w_alloc_fire) r_tail <= r_tail + 1'b1;
      if (w_res_fire)   r_head <= r_head + 1'b1;
      r_count <= r_count + c_CNT_W'(w_alloc_fire) - c_CNT_W'(w_res_fire);
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_is_branch   <= 1'b0;
      r_is_taken    <= 1'b0;
      r_instr_pc    <= '0;
      r_mispredict  <= 1'b0;
      r_redirect_pc <= '0;
      r_underflow   <= 1'b0;
    end else begin
      r_is_branch  <= w_res_fire;
      r_mispredict <= w_mispred;
      r_underflow  <= r_underflow | w_res_empty;
      if (w_res_fire) begin
        r_is_taken    <= bus.res_taken;
        r_instr_pc    <= w_head_pc;
        r_redirect_pc <= bus.res_taken ? bus.res_target : (w_head_pc + 32'd4);
      end
    end
  end

  assign bus.alloc_ready = w_alloc_ready;
  assign bus.isBranch    = r_is_branch;
  assign bus.isTaken     = r_is_taken;
  assign bus.InstrPC     = r_instr_pc;
  assign bus.mispredict  = r_mispredict;
  assign bus.redirect_pc = r_redirect_pc;
  assign bus.count       = r_count;
  assign bus.underflow   = r_underflow;
endmodule
`default_nettype wire
